fuel_pump_guard: RTL and testbench

Parametrised successor to the single-switch fuel-pump interlock in the automotive anti-theft system. It checks an N-bit hidden-switch code, which must be presented on a brake press. Failed attempts and arming timeouts are counted, and the block enters a timed alarm lockout after too many failures. Once the pump is enabled, it tolerates short ignition dropouts. It sits between the ignition/brake/switch input conditioning and the fuel-pump relay and alarm drivers.

---
 rtl/fuel_guard_pkg.sv | 18 +
 rtl/guard_timer.sv | 22 ++
 rtl/fuel_pump_guard.sv | 122 ++++++++++++
 tb/tb_fuel_pump_guard.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fuel_guard_pkg.sv
// fuel_guard_pkg: state encodings and sizing helpers shared by the fuel-pump guard.
package fuel_guard_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2,
        LOCKOUT = 2'd3
    } state_t;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/guard_timer.sv
// guard_timer: loadable down-counter that saturates at zero and flags it.
module guard_timer #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/fuel_pump_guard.sv
// fuel_pump_guard: hidden-switch fuel-pump interlock with retry counting,
// arming timeout, timed alarm lockout and ignition-dropout tolerance.
module fuel_pump_guard
    import fuel_guard_pkg::*;
#(
    parameter int                NUM_SW         = 4,
    parameter logic [NUM_SW-1:0] CODE           = 4'b1010,
    parameter int                MAX_TRIES      = 3,
    parameter int                ARM_TIMEOUT    = 16,
    parameter int                LOCKOUT_CYCLES = 32,
    parameter int                IGN_GRACE      = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           ignition,
    input  logic                           brake,
    input  logic [NUM_SW-1:0]              hidden_sw,
    output logic                           fuel_pump,
    output logic                           alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic [STATE_W-1:0]             state_o
);
    localparam int TW = width_of(max3(ARM_TIMEOUT, LOCKOUT_CYCLES, IGN_GRACE));
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] ARM_LD   = TW'(ARM_TIMEOUT - 1);
    localparam logic [TW-1:0] LOCK_LD  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] GRACE_LD = TW'(IGN_GRACE - 1);
    localparam logic [FW-1:0] MAX_F    = FW'(MAX_TRIES);
    localparam logic [FW-1:0] LAST_F   = FW'(MAX_TRIES - 1);

    state_t        r_state, w_next;
    logic [FW-1:0] r_fail, w_fail_nx;
    logic          r_brake_q;
    logic          w_brake_rise, w_load, w_dec, w_zero;
    logic [TW-1:0] w_load_val;

    assign w_brake_rise = brake & ~r_brake_q;

    guard_timer #(.W(TW)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_fail    <= '0;
            r_brake_q <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_fail    <= w_fail_nx;
            r_brake_q <= brake;
        end
    end

    // Priority in ARMED: ignition loss, then a brake attempt, then timer expiry.
    always_comb begin
        w_next     = r_state;
        w_fail_nx  = r_fail;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (ignition) begin
                    w_next     = ARMED;
                    w_load     = 1'b1;
                    w_load_val = ARM_LD;
                end
            end
            ARMED: begin
                if (!ignition) begin
                    w_next = IDLE;
                end else if (w_brake_rise && hidden_sw == CODE) begin
                    w_next     = RUNNING;
                    w_fail_nx  = '0;
                    w_load     = 1'b1;
                    w_load_val = GRACE_LD;
                end else if (w_brake_rise || w_zero) begin
                    w_load = 1'b1;
                    if (r_fail == LAST_F) begin
                        w_next     = LOCKOUT;
                        w_load_val = LOCK_LD;
                    end else begin
                        w_fail_nx  = r_fail + 1'b1;
                        w_load_val = ARM_LD;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            RUNNING: begin
                if (ignition) begin
                    w_load     = 1'b1;
                    w_load_val = GRACE_LD;
                end else if (!w_zero) begin
                    w_dec = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            LOCKOUT: begin
                if (w_zero) begin
                    w_next    = IDLE;
                    w_fail_nx = '0;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign fuel_pump  = (r_state == RUNNING);
    assign alarm      = (r_state == LOCKOUT);
    assign tries_left = (r_state == LOCKOUT) ? '0 : MAX_F - r_fail;
    assign state_o    = r_state;
endmodule

// File: tb/tb_fuel_pump_guard.sv
// tb_fuel_pump_guard: directed scenario tests for fuel_pump_guard at default parameters.
module tb_fuel_pump_guard;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ignition = 1'b0;
    logic       brake = 1'b0;
    logic [3:0] hidden_sw = 4'b0000;
    logic       fuel_pump, alarm;
    logic [1:0] tries_left, state_o;
    int         n_cmp = 0;
    int         n_bad = 0;

    localparam logic [3:0] GOOD = 4'b1010;

    fuel_pump_guard dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ignition   (ignition),
        .brake      (brake),
        .hidden_sw  (hidden_sw),
        .fuel_pump  (fuel_pump),
        .alarm      (alarm),
        .tries_left (tries_left),
        .state_o    (state_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic go_idle();
        ignition = 1'b0;
        brake = 1'b0;
        step(4);
        n_cmp++;
        if (state_o !== 2'd0) begin n_bad++; $display("FAIL go_idle_state: got %0d want 0", state_o); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if (fuel_pump !== 1'b0) begin n_bad++; $display("FAIL reset_pump: got %b want 0", fuel_pump); end
        n_cmp++;
        if (alarm !== 1'b0) begin n_bad++; $display("FAIL reset_alarm: got %b want 0", alarm); end
        n_cmp++;
        if (tries_left !== 2'd3) begin n_bad++; $display("FAIL reset_tries: got %0d want 3", tries_left); end
        n_cmp++;
        if (state_o !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
        #2 reset_n = 1'b1;
    endtask

    task automatic test_unlock();
        ignition = 1'b1;
        step();
        n_cmp++;
        if (state_o !== 2'd1) begin n_bad++; $display("FAIL unlock_armed: got %0d want 1", state_o); end
        brake = 1'b1;
        hidden_sw = GOOD;
        step();
        n_cmp++;
        if (fuel_pump !== 1'b1) begin n_bad++; $display("FAIL unlock_pump: got %b want 1", fuel_pump); end
        n_cmp++;
        if (tries_left !== 2'd3) begin n_bad++; $display("FAIL unlock_tries: got %0d want 3", tries_left); end
        go_idle();
    endtask

    task automatic test_wrong_then_right();
        ignition = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            brake = 1'b1;
            hidden_sw = 4'b0000;
            step();
            n_cmp++;
            if (tries_left !== 2'(2 - k)) begin n_bad++; $display("FAIL wrong_tries%0d: got %0d want %0d", k, tries_left, 2 - k); end
            brake = 1'b0;
            step();
        end
        brake = 1'b1;
        hidden_sw = GOOD;
        step();
        n_cmp++;
        if (fuel_pump !== 1'b1) begin n_bad++; $display("FAIL right_pump: got %b want 1", fuel_pump); end
        n_cmp++;
        if (tries_left !== 2'd3) begin n_bad++; $display("FAIL right_tries: got %0d want 3", tries_left); end
        go_idle();
    endtask

    task automatic test_lockout();
        int n_high;
        ignition = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            brake = 1'b1;
            hidden_sw = 4'b0000;
            step();
            if (k < 2) begin
                brake = 1'b0;
                step();
            end
        end
        n_cmp++;
        if (state_o !== 2'd3 || alarm !== 1'b1) begin n_bad++; $display("FAIL lockout_enter: got state %0d alarm %b want 3 1", state_o, alarm); end
        n_cmp++;
        if (tries_left !== 2'd0) begin n_bad++; $display("FAIL lockout_tries: got %0d want 0", tries_left); end
        n_high = 1;
        hidden_sw = GOOD;
        for (int i = 0; i < 40; i++) begin
            ignition = i[0];
            brake = i[1];
            step();
            if (alarm !== 1'b1) break;
            n_high++;
        end
        n_cmp++;
        if (n_high !== 32) begin n_bad++; $display("FAIL lockout_len: got %0d cycles want 32", n_high); end
        n_cmp++;
        if (state_o !== 2'd0 || tries_left !== 2'd3) begin n_bad++; $display("FAIL lockout_exit: got state %0d tries %0d want 0 3", state_o, tries_left); end
        ignition = 1'b0;
        brake = 1'b0;
        step();
    endtask

    task automatic test_timeout_and_reset();
        ignition = 1'b1;
        brake = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step(15);
            n_cmp++;
            if (tries_left !== 2'(3 - k) || state_o !== 2'd1) begin n_bad++; $display("FAIL timeout_hold%0d: got tries %0d state %0d want %0d 1", k, tries_left, state_o, 3 - k); end
            step();
            if (k < 2) begin
                n_cmp++;
                if (tries_left !== 2'(2 - k)) begin n_bad++; $display("FAIL timeout_dec%0d: got %0d want %0d", k, tries_left, 2 - k); end
            end
        end
        n_cmp++;
        if (alarm !== 1'b1 || state_o !== 2'd3) begin n_bad++; $display("FAIL timeout_lockout: got alarm %b state %0d want 1 3", alarm, state_o); end
        step(5);
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (alarm !== 1'b0) begin n_bad++; $display("FAIL midreset_alarm: got %b want 0", alarm); end
        n_cmp++;
        if (tries_left !== 2'd3 || state_o !== 2'd0) begin n_bad++; $display("FAIL midreset_state: got tries %0d state %0d want 3 0", tries_left, state_o); end
        ignition = 1'b0;
        #2 reset_n = 1'b1;
        step();
    endtask

    task automatic test_dropout();
        ignition = 1'b1;
        step();
        brake = 1'b1;
        hidden_sw = GOOD;
        step();
        brake = 1'b0;
        ignition = 1'b0;
        step(3);
        n_cmp++;
        if (fuel_pump !== 1'b1) begin n_bad++; $display("FAIL dropout_3low: got %b want 1", fuel_pump); end
        ignition = 1'b1;
        step();
        ignition = 1'b0;
        step(3);
        n_cmp++;
        if (fuel_pump !== 1'b1) begin n_bad++; $display("FAIL dropout_restart: got %b want 1", fuel_pump); end
        step();
        n_cmp++;
        if (fuel_pump !== 1'b0 || state_o !== 2'd0) begin n_bad++; $display("FAIL dropout_4low: got pump %b state %0d want 0 0", fuel_pump, state_o); end
    endtask

    task automatic test_priority();
        ignition = 1'b1;
        step();
        ignition = 1'b0;
        brake = 1'b1;
        hidden_sw = GOOD;
        step();
        n_cmp++;
        if (state_o !== 2'd0 || fuel_pump !== 1'b0) begin n_bad++; $display("FAIL prio_ign_low: got state %0d pump %b want 0 0", state_o, fuel_pump); end
        brake = 1'b0;
        ignition = 1'b1;
        step();
        step(15);
        brake = 1'b1;
        hidden_sw = 4'b0000;
        step();
        n_cmp++;
        if (tries_left !== 2'd2 || state_o !== 2'd1) begin n_bad++; $display("FAIL prio_rise_expiry: got tries %0d state %0d want 2 1", tries_left, state_o); end
        brake = 1'b0;
        step(15);
        n_cmp++;
        if (tries_left !== 2'd2) begin n_bad++; $display("FAIL prio_reload: got %0d want 2", tries_left); end
        step();
        n_cmp++;
        if (tries_left !== 2'd1) begin n_bad++; $display("FAIL prio_reload_exp: got %0d want 1", tries_left); end
        ignition = 1'b0;
        step();
        n_cmp++;
        if (state_o !== 2'd0 || tries_left !== 2'd1) begin n_bad++; $display("FAIL persist_idle: got state %0d tries %0d want 0 1", state_o, tries_left); end
        ignition = 1'b1;
        step();
        brake = 1'b1;
        hidden_sw = GOOD;
        step();
        n_cmp++;
        if (fuel_pump !== 1'b1 || tries_left !== 2'd3) begin n_bad++; $display("FAIL persist_unlock: got pump %b tries %0d want 1 3", fuel_pump, tries_left); end
        go_idle();
    endtask

    task automatic test_brake_held_reset();
        #3 reset_n = 1'b0;
        brake = 1'b1;
        ignition = 1'b1;
        hidden_sw = 4'b0000;
        #10 reset_n = 1'b1;
        step(2);
        n_cmp++;
        if (state_o !== 2'd1 || tries_left !== 2'd3) begin n_bad++; $display("FAIL held_brake: got state %0d tries %0d want 1 3", state_o, tries_left); end
        brake = 1'b0;
        step();
        brake = 1'b1;
        hidden_sw = GOOD;
        step();
        n_cmp++;
        if (fuel_pump !== 1'b1) begin n_bad++; $display("FAIL held_brake_rise: got %b want 1", fuel_pump); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_wrong_then_right();
        test_lockout();
        test_timeout_and_reset();
        test_dropout();
        test_priority();
        test_brake_held_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
